// File: rtl/pe_conf_loader.sv
// pe_conf_loader: gathers NWORD raw config words into a PECfg::Conf and hands it to the PE.
// Define PE_CONF_CHECK_EN to reject frames with out-of-range sizes or zero dimensions (o_err).
package RFCfg;
  typedef enum logic [1:0] {DWD_8B, DWD_16B, DWD_24B, DWD_32B} DWD_mode;
endpackage

package PECfg;
  import RFCfg::DWD_mode;

  localparam int PCONFDWD = 6;
  localparam int WPADSIZE = 48;
  localparam int IPADSIZE = 16;
  localparam int PPADSIZE = 100;

  typedef logic [6:0] wpad_t;
  typedef logic [4:0] ipad_t;
  typedef logic [6:0] ppad_t;
  typedef logic [5:0] upix_t;

  typedef struct packed {
    logic [3:0] Pch;
    logic [4:0] Pm;
    logic [2:0] Au;
    logic [2:0] Tb;
    logic [2:0] U;
    logic       XNumT;
    logic       WNumT;
    logic [2:0] R;
    logic [2:0] S;
    logic [3:0] Xb;
    logic [3:0] Wb;
    logic [3:0] Wb_idx;
    DWD_mode    Psum_mode;
    logic [6:0] Tw;
    wpad_t      wpad_size;
    ipad_t      ipad_size;
    ppad_t      ppad_size;
    upix_t      Upix;
    logic       PixReuse;
  } Conf;

  typedef struct packed {
    logic       start;
    logic [2:0] op;
    logic [3:0] tag;
  } Inst;
endpackage

module pe_conf_loader
  import PECfg::*;
  import RFCfg::DWD_mode;
#(
  parameter int NWORD = 12
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [PCONFDWD-1:0]       i_word,
  input  logic                      i_word_vld,
  output logic                      o_word_rdy,
  input  logic                      i_abort,
  output logic [$bits(Conf)-1:0]    o_conf,
  output logic                      o_conf_vld,
  input  logic                      i_conf_rdy,
  output logic [$bits(Inst)-1:0]    o_inst,
  output logic                      o_err
);

  localparam int CW = (NWORD > 1) ? $clog2(NWORD) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, HOLD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  Conf           stg_q, calc;
  Inst           inst_w;
  logic          start_q;
  logic          xfer, take_word, last_word, reject;

  assign o_word_rdy = !i_rst && (state_q == IDLE || state_q == LOAD);
  assign xfer       = i_word_vld && o_word_rdy;
  assign take_word  = xfer && !i_abort;
  assign last_word  = (cnt_q == CW'(NWORD - 1));
  assign o_conf_vld = (state_q == HOLD);

`ifdef PE_CONF_CHECK_EN
  logic err_q;

  // Limits are judged on the untruncated products so oversize frames cannot alias into range.
  always_comb begin
    reject = (12'(stg_q.Pch) * 12'(stg_q.Pm) * 12'(stg_q.R) > 12'(WPADSIZE)) ||
             (8'(stg_q.Pch) * 8'(stg_q.R) > 8'(IPADSIZE)) ||
             (12'(stg_q.Pm) * 12'(stg_q.Tw) > 12'(PPADSIZE)) ||
             (stg_q.Pch == '0) || (stg_q.Pm == '0) ||
             (stg_q.R == '0) || (stg_q.U == '0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) err_q <= 1'b0;
    else       err_q <= (state_q == CALC) && !i_abort && reject;
  end

  assign o_err = err_q;
`else
  assign reject = 1'b0;
  assign o_err  = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (take_word) state_d = last_word ? CALC : LOAD;
      LOAD: begin
        if (i_abort)                       state_d = IDLE;
        else if (take_word && last_word)   state_d = CALC;
      end
      CALC: state_d = (i_abort || reject) ? IDLE : HOLD;
      HOLD: if (i_conf_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          cnt_q <= '0;
    else if (i_abort)   cnt_q <= '0;
    else if (take_word) cnt_q <= last_word ? '0 : cnt_q + CW'(1);
  end

  // Staging register: each word lands in its fields as it arrives.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stg_q <= '0;
    end else if (take_word) begin
      case (int'(cnt_q))
        0:  stg_q.Pch <= i_word[3:0];
        1:  stg_q.Pm  <= i_word[4:0];
        2:  begin stg_q.Au <= i_word[2:0]; stg_q.Tb <= i_word[5:3]; end
        3:  begin stg_q.U <= i_word[2:0]; stg_q.XNumT <= i_word[3]; stg_q.WNumT <= i_word[4]; end
        4:  stg_q.R      <= i_word[2:0];
        5:  stg_q.S      <= i_word[2:0];
        6:  stg_q.Xb     <= i_word[3:0];
        7:  stg_q.Wb     <= i_word[3:0];
        8:  stg_q.Wb_idx <= i_word[3:0];
        9:  stg_q.Psum_mode <= DWD_mode'(i_word[$bits(DWD_mode)-1:0]);
        10: stg_q.Tw[5:0] <= i_word[5:0];
        11: stg_q.Tw[6]   <= i_word[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    calc           = stg_q;
    calc.wpad_size = wpad_t'(12'(stg_q.Pch) * 12'(stg_q.Pm) * 12'(stg_q.R));
    calc.ipad_size = ipad_t'(8'(stg_q.Pch) * 8'(stg_q.R));
    calc.ppad_size = ppad_t'(12'(stg_q.Pm) * 12'(stg_q.Tw));
    calc.Upix      = upix_t'(8'(stg_q.U) * 8'(stg_q.Pch));
    calc.PixReuse  = (stg_q.R < stg_q.U) || (stg_q.R == 3'd1);
  end

  // o_conf only changes when a new frame is published, so it stays put through backpressure.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_conf  <= '0;
      start_q <= 1'b0;
    end else begin
      if (state_q == CALC && state_d == HOLD) o_conf <= calc;
      start_q <= (state_q == HOLD) && i_conf_rdy;
    end
  end

  always_comb begin
    inst_w       = '0;
    inst_w.start = start_q;
  end

  assign o_inst = inst_w;

endmodule

// File: tb/tb_pe_conf_loader.sv
// Directed self-checking bench for pe_conf_loader; expectations follow PE_CONF_CHECK_EN when defined.
module tb_pe_conf_loader;
  import PECfg::*;
  import RFCfg::*;

  logic                   i_clk = 1'b0;
  logic                   i_rst = 1'b1;
  logic [PCONFDWD-1:0]    i_word = '0;
  logic                   i_word_vld = 1'b0;
  logic                   o_word_rdy;
  logic                   i_abort = 1'b0;
  logic [$bits(Conf)-1:0] o_conf;
  logic                   o_conf_vld;
  logic                   i_conf_rdy = 1'b0;
  logic [$bits(Inst)-1:0] o_inst;
  logic                   o_err;

  int  total = 0;
  int  bad   = 0;
  logic [PCONFDWD-1:0] words [12];
  Conf exp_conf;
  Inst inst_start;
  Inst inst_idle;

  pe_conf_loader #(.NWORD(12)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_word(i_word), .i_word_vld(i_word_vld),
    .o_word_rdy(o_word_rdy), .i_abort(i_abort), .o_conf(o_conf),
    .o_conf_vld(o_conf_vld), .i_conf_rdy(i_conf_rdy), .o_inst(o_inst), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Builds the raw words (with junk in unused bits) and the raw part of the expected conf.
  task automatic make_frame(input int pch, pm, au, tb, u, xn, wn, r, s, xb, wb, wbi, psum, tw);
    logic [6:0] twv;
    twv = 7'(tw);
    words[0]  = {2'b11, 4'(pch)};
    words[1]  = {1'b1, 5'(pm)};
    words[2]  = {3'(tb), 3'(au)};
    words[3]  = {1'b1, 1'(wn), 1'(xn), 3'(u)};
    words[4]  = {3'b101, 3'(r)};
    words[5]  = {3'b110, 3'(s)};
    words[6]  = {2'b10, 4'(xb)};
    words[7]  = {2'b01, 4'(wb)};
    words[8]  = {2'b11, 4'(wbi)};
    words[9]  = {4'b1011, 2'(psum)};
    words[10] = twv[5:0];
    words[11] = {5'b10101, twv[6]};
    exp_conf           = '0;
    exp_conf.Pch       = 4'(pch);
    exp_conf.Pm        = 5'(pm);
    exp_conf.Au        = 3'(au);
    exp_conf.Tb        = 3'(tb);
    exp_conf.U         = 3'(u);
    exp_conf.XNumT     = 1'(xn);
    exp_conf.WNumT     = 1'(wn);
    exp_conf.R         = 3'(r);
    exp_conf.S         = 3'(s);
    exp_conf.Xb        = 4'(xb);
    exp_conf.Wb        = 4'(wb);
    exp_conf.Wb_idx    = 4'(wbi);
    exp_conf.Psum_mode = DWD_mode'(2'(psum));
    exp_conf.Tw        = twv;
  endtask

  task automatic apply_stimulus(input logic [PCONFDWD-1:0] w);
    int n = 0;
    while (!o_word_rdy && n < 20) begin
      @(posedge i_clk); #1;
      n++;
    end
    check_output("word_rdy_wait", o_word_rdy, 1'b1);
    i_word     = w;
    i_word_vld = 1'b1;
    @(posedge i_clk); #1;
    i_word_vld = 1'b0;
  endtask

  task automatic send_words(input int count);
    for (int i = 0; i < count; i++) apply_stimulus(words[i]);
  endtask

  // After the last word: one CALC cycle, then HOLD with o_conf_vld.
  task automatic expect_publish(input string tag);
    @(negedge i_clk);
    check_output({tag, "_calc_vld"}, o_conf_vld, 1'b0);
    check_output({tag, "_calc_rdy"}, o_word_rdy, 1'b0);
    check_output({tag, "_calc_inst"}, o_inst, inst_idle);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check_output({tag, "_hold_vld"}, o_conf_vld, 1'b1);
    check_output({tag, "_hold_rdy"}, o_word_rdy, 1'b0);
    check_output({tag, "_conf"}, o_conf, exp_conf);
  endtask

  task automatic expect_start(input string tag);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check_output({tag, "_start"}, o_inst, inst_start);
    check_output({tag, "_vld_drop"}, o_conf_vld, 1'b0);
    check_output({tag, "_rdy_back"}, o_word_rdy, 1'b1);
    check_output({tag, "_conf_kept"}, o_conf, exp_conf);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check_output({tag, "_start_end"}, o_inst, inst_idle);
  endtask

  initial begin
    inst_idle        = '0;
    inst_start       = '0;
    inst_start.start = 1'b1;

    // Reset state
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check_output("rst_rdy", o_word_rdy, 1'b0);
    check_output("rst_vld", o_conf_vld, 1'b0);
    check_output("rst_conf", o_conf, '0);
    check_output("rst_inst", o_inst, inst_idle);
    check_output("rst_err", o_err, 1'b0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check_output("post_rst_rdy", o_word_rdy, 1'b1);

    // Nominal frame; conf_rdy already high must not cause an early transfer
    $display("[TB] nominal frame");
    i_conf_rdy = 1'b1;
    make_frame(2, 4, 1, 2, 1, 1, 0, 3, 3, 5, 6, 7, 2, 8);
    exp_conf.wpad_size = 7'd24;
    exp_conf.ipad_size = 5'd6;
    exp_conf.ppad_size = 7'd32;
    exp_conf.Upix      = 6'd2;
    exp_conf.PixReuse  = 1'b0;
    send_words(12);
    expect_publish("nom");
    expect_start("nom");

    // Backpressure with R=2,U=3 -> PixReuse
    $display("[TB] backpressure frame");
    i_conf_rdy = 1'b0;
    make_frame(3, 2, 3, 5, 3, 0, 1, 2, 1, 9, 10, 11, 1, 5);
    exp_conf.wpad_size = 7'd12;
    exp_conf.ipad_size = 5'd6;
    exp_conf.ppad_size = 7'd10;
    exp_conf.Upix      = 6'd9;
    exp_conf.PixReuse  = 1'b1;
    send_words(12);
    expect_publish("bp");
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk); #1;
      i_word     = 6'h3f;
      i_word_vld = 1'b1;
      i_abort    = (i == 2);
      @(negedge i_clk);
      check_output("bp_hold_vld", o_conf_vld, 1'b1);
      check_output("bp_hold_rdy", o_word_rdy, 1'b0);
      check_output("bp_hold_conf", o_conf, exp_conf);
      check_output("bp_hold_inst", o_inst, inst_idle);
    end
    i_word_vld = 1'b0;
    i_abort    = 1'b0;
    i_conf_rdy = 1'b1;
    expect_start("bp");
    i_conf_rdy = 1'b0;

    // Oversize weight pad: rejected with checks, published truncated without
    $display("[TB] oversize frame");
    i_conf_rdy = 1'b1;
    make_frame(4, 4, 0, 0, 1, 0, 0, 4, 4, 0, 0, 0, 0, 8);
    exp_conf.wpad_size = 7'd64;
    exp_conf.ipad_size = 5'd16;
    exp_conf.ppad_size = 7'd32;
    exp_conf.Upix      = 6'd4;
    exp_conf.PixReuse  = 1'b0;
    send_words(12);
`ifdef PE_CONF_CHECK_EN
    @(negedge i_clk);
    check_output("chk_calc_err", o_err, 1'b0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check_output("chk_err_pulse", o_err, 1'b1);
    check_output("chk_no_vld", o_conf_vld, 1'b0);
    check_output("chk_rdy", o_word_rdy, 1'b1);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check_output("chk_err_end", o_err, 1'b0);
    check_output("chk_no_vld2", o_conf_vld, 1'b0);
    check_output("chk_no_start", o_inst, inst_idle);
`else
    expect_publish("nochk");
    check_output("nochk_err", o_err, 1'b0);
    expect_start("nochk");
`endif

    // Abort after six words (abort beats a simultaneous word), then a clean frame
    $display("[TB] abort then reload");
    make_frame(2, 4, 1, 2, 1, 1, 0, 3, 3, 5, 6, 7, 2, 8);
    send_words(6);
    i_word     = words[6];
    i_word_vld = 1'b1;
    i_abort    = 1'b1;
    @(posedge i_clk); #1;
    i_word_vld = 1'b0;
    i_abort    = 1'b0;
    @(negedge i_clk);
    check_output("abort_rdy", o_word_rdy, 1'b1);
    check_output("abort_vld", o_conf_vld, 1'b0);
    check_output("abort_err", o_err, 1'b0);
    repeat (2) @(posedge i_clk);
    #1;
    @(negedge i_clk);
    check_output("abort_still_idle", o_conf_vld, 1'b0);
    make_frame(5, 1, 2, 1, 1, 1, 1, 1, 2, 3, 4, 5, 3, 70);
    exp_conf.wpad_size = 7'd5;
    exp_conf.ipad_size = 5'd5;
    exp_conf.ppad_size = 7'd70;
    exp_conf.Upix      = 6'd5;
    exp_conf.PixReuse  = 1'b1;
    @(posedge i_clk); #1;
    send_words(12);
    expect_publish("reload");
    expect_start("reload");

    // Reset while holding a conf
    $display("[TB] reset in hold");
    i_conf_rdy = 1'b0;
    make_frame(2, 4, 1, 2, 1, 1, 0, 3, 3, 5, 6, 7, 2, 8);
    exp_conf.wpad_size = 7'd24;
    exp_conf.ipad_size = 5'd6;
    exp_conf.ppad_size = 7'd32;
    exp_conf.Upix      = 6'd2;
    exp_conf.PixReuse  = 1'b0;
    send_words(12);
    expect_publish("rsth");
    i_rst = 1'b1;
    #1;
    check_output("rsth_vld", o_conf_vld, 1'b0);
    check_output("rsth_conf", o_conf, '0);
    check_output("rsth_rdy", o_word_rdy, 1'b0);
    i_conf_rdy = 1'b1;
    @(posedge i_clk); #1;
    check_output("rsth_no_start", o_inst, inst_idle);
    i_rst = 1'b0;
    @(negedge i_clk);
    check_output("rsth_release_rdy", o_word_rdy, 1'b1);
    check_output("rsth_release_inst", o_inst, inst_idle);
    check_output("rsth_release_vld", o_conf_vld, 1'b0);
    i_conf_rdy = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_conf_loader.md
PE_CONF_LOADER -- requirements
Module: pe_conf_loader

Interface
REQ-001 SHALL import PECfg::* and RFCfg::DWD_mode; parameter NWORD, default 12, number of config words per frame.
REQ-002 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_word  input  PCONFDWD  raw config word.
REQ-005 SHALL have ports i_word_vld input 1 / o_word_rdy output 1  word handshake; transfer when both high.
REQ-006 SHALL have port i_abort  input  1  synchronous frame discard.
REQ-007 SHALL have port o_conf  output  $bits(Conf)  assembled PECfg::Conf.
REQ-008 SHALL have ports o_conf_vld output 1 / i_conf_rdy input 1  conf handshake toward PE.
REQ-009 SHALL have port o_inst  output  $bits(Inst)  PECfg::Inst; only start driven, other fields 0.
REQ-010 SHALL have port o_err  output  1  one-cycle pulse on rejected frame.

Function
REQ-011 SHALL implement FSM IDLE -> LOAD -> CALC -> HOLD -> IDLE; IDLE leaves to LOAD on first accepted word.
REQ-012 SHALL assert o_word_rdy only in IDLE and LOAD.
REQ-013 SHALL use word counter 0..NWORD-1, increment per transfer, wrap to 0 on the last word with transition LOAD -> CALC.
REQ-014 SHALL map words (low bits, unused bits ignored): w0 Pch[3:0]; w1 Pm[4:0]; w2 Au[2:0], Tb at [5:3]; w3 U[2:0], XNumT [3], WNumT [4]; w4 R; w5 S; w6 Xb; w7 Wb; w8 Wb_idx; w9 Psum_mode low $bits(DWD_mode); w10 Tw[5:0]; w11 bit0 Tw[6].
REQ-015 SHALL in CALC (exactly one cycle) compute wpad_size=Pch*Pm*R, ipad_size=Pch*R, ppad_size=Pm*Tw, Upix=U*Pch with full-width products, then truncate to field width.
REQ-016 SHALL set PixReuse = (R < U) or (R == 1).
REQ-017 SHALL enter HOLD with o_conf_vld=1 the cycle after CALC; conf latency from last word transfer = 2 cycles.
REQ-018 SHALL hold o_conf stable while o_conf_vld=1 and i_conf_rdy=0.
REQ-019 SHALL on conf transfer drop o_conf_vld, pulse o_inst.start for 1 cycle, return to IDLE; o_conf retains last value.
REQ-020 SHALL treat i_conf_rdy high before o_conf_vld as don't-care (no early transfer).
REQ-021 SHALL on i_abort in LOAD or CALC clear counter and return to IDLE with no conf, no err; i_abort in HOLD ignored; abort wins over a simultaneous word transfer.
REQ-022 SHALL not accept words in CALC or HOLD; back-to-back frames resume the cycle after HOLD exit.

Reset
REQ-023 SHALL on i_rst: state IDLE, counter 0, o_conf all zero, o_conf_vld 0, o_inst 0, o_err 0, o_word_rdy 0 during reset and 1 from first cycle after release.
REQ-024 SHALL treat reset mid-frame or in HOLD as full discard; no start pulse emitted.

Configuration
REQ-025 SHALL honour macro PE_CONF_CHECK_EN.
REQ-026 SHALL with PE_CONF_CHECK_EN defined, in CALC reject frames where untruncated wpad>WPADSIZE, ipad>IPADSIZE, ppad>PPADSIZE, Pch=0, Pm=0, R=0 or U=0: pulse o_err 1 cycle, go IDLE, never assert o_conf_vld.
REQ-027 SHALL without PE_CONF_CHECK_EN, omit all checks, tie o_err to 0, always proceed CALC -> HOLD.

Verification
REQ-028 SHALL cover nominal: Pch=2,Pm=4,R=3,U=1,Tw=8 -> wpad=24, ipad=6, ppad=32, Upix=2, PixReuse=0; o_conf_vld 2 cycles after w11; start pulse on handshake.
REQ-029 SHALL cover backpressure: i_conf_rdy low 5 cycles -> o_conf stable, o_word_rdy 0, then single start pulse.
REQ-030 SHALL cover check (macro on): Pch=4,Pm=4,R=4 (wpad 64>48) -> o_err pulse, no o_conf_vld; macro off -> o_conf_vld with wpad=64 truncated to 7 bits = 64.
REQ-031 SHALL cover abort after w5 -> counter 0; next full frame assembles correctly.
REQ-032 SHALL cover i_rst asserted in HOLD -> o_conf_vld 0 immediately, no start pulse, o_conf 0.
REQ-033 SHALL cover R=2,U=3 -> PixReuse=1; R=1,U=1 -> PixReuse=1.
